// File: rtl/cla_nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_seq_adder
// Purpose  : WIDTH-bit adder that time-shares one 4-bit carry-look-ahead slice,
//            processing one nibble per cycle LSB first, with valid/ready in/out.
// Revision : 1.0
// ============================================================================
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] nr1,
    input  logic [WIDTH-1:0] nr2,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB  = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_armed;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [3:0]       w_c;
    logic [3:0]       w_slice_sum;
    logic             w_grp_g;
    logic             w_grp_p;
    logic             w_carry_next;
    logic             w_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && in_ready) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic; r_armed keeps in_ready low until the first edge after reset
    always_comb begin
        in_ready  = (r_state == S_IDLE) && r_armed;
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
    end

    // 4-bit carry-look-ahead slice
    always_comb begin
        w_a_nib = r_a[4*r_idx +: 4];
        w_b_nib = r_b[4*r_idx +: 4];
        w_g     = w_a_nib & w_b_nib;
        w_p     = w_a_nib ^ w_b_nib;
        w_c[0]  = r_carry;
        w_c[1]  = w_g[0] | (w_p[0] & r_carry);
        w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_slice_sum = w_p ^ w_c;
        w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        w_grp_p = &w_p;
        w_carry_next = w_grp_g | (w_grp_p & r_carry);
        w_last  = (r_idx == LAST_IDX);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a     <= nr1;
                        r_b     <= nr2;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_slice_sum;
                    r_carry <= w_carry_next;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        // Final slice sum bit 3 is the result MSB
                        r_cout <= w_carry_next;
                        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_slice_sum[3] != r_a[MSB]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_nibble_seq_adder
// Purpose  : Directed WIDTH=16 and randomised WIDTH=8 checks of the sequential
//            nibble adder against a plain-arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_cla_nibble_seq_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 1'b0, iv16 = 1'b0, ir16, ov16, or16 = 1'b0, co16, ovf16, busy16;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        cin8 = 1'b0, iv8 = 1'b0, ir8, ov8, or8 = 1'b0, co8, ovf8, busy8;

    cla_nibble_seq_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .nr1(a16), .nr2(b16),
        .carry_in(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .carry_out(co16), .overflow(ovf16), .busy(busy16)
    );

    cla_nibble_seq_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .nr1(a8), .nr2(b8),
        .carry_in(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .carry_out(co8), .overflow(ovf8), .busy(busy8)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {overflow, carry_out, sum} of a w-bit add with carry-in
    function automatic logic [33:0] ref_add(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] full;
        logic [32:0] lim;
        logic [31:0] s;
        logic        co;
        logic        ov;
        full = {1'b0, a} + {1'b0, b} + 33'(cin);
        lim  = 33'(1) << w;
        s    = full[31:0] & 32'(lim - 33'(1));
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic run_op16(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [15:0] es, input logic ec,
                            input logic eo, input int hold);
        logic [33:0] m;
        int cnt;
        m = ref_add(16, {16'h0, a}, {16'h0, b}, cin);
        check({name, " model sum"}, m[31:0], {16'h0, es});
        check({name, " model cout"}, {31'h0, m[32]}, {31'h0, ec});
        check({name, " model ovf"}, {31'h0, m[33]}, {31'h0, eo});
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = cin; iv16 = 1'b1; or16 = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!ir16 && cnt < 20);
        if (!ir16) begin
            check({name, " accept timeout"}, 32'd1, 32'd0);
            iv16 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        cnt = 1;
        @(negedge clk);
        while (!ov16 && cnt < 20) begin @(negedge clk); cnt++; end
        check({name, " latency"}, 32'(cnt), 32'd5);
        check({name, " sum"}, {16'h0, s16}, {16'h0, es});
        check({name, " cout"}, {31'h0, co16}, {31'h0, ec});
        check({name, " ovf"}, {31'h0, ovf16}, {31'h0, eo});
        check({name, " busy"}, {31'h0, busy16}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            @(negedge clk);
            check({name, " held valid"}, {31'h0, ov16}, 32'd1);
            check({name, " held sum"}, {16'h0, s16}, {16'h0, es});
            check({name, " held cout/ovf"}, {30'h0, co16, ovf16}, {30'h0, ec, eo});
            check({name, " in_ready in DONE"}, {31'h0, ir16}, 32'd0);
        end
        @(posedge clk); #1;
        iv16 = 1'b0; or16 = 1'b1;
        @(negedge clk);
        check({name, " valid before consume"}, {31'h0, ov16}, 32'd1);
        @(posedge clk); #1;
        or16 = 1'b0;
        @(negedge clk);
        check({name, " valid dropped"}, {31'h0, ov16}, 32'd0);
        check({name, " in_ready after"}, {31'h0, ir16}, 32'd1);
        check({name, " busy after"}, {31'h0, busy16}, 32'd0);
    endtask

    // Scoreboard for the WIDTH=8 instance
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp8_t;
    exp8_t q8[$];
    int results8 = 0;
    int accepts8 = 0;
    int wait_cnt = -1;

    always @(negedge clk) begin
        logic [33:0] m;
        if (!rst) begin
            if (wait_cnt >= 0) wait_cnt++;
            if (ov8) begin
                if (wait_cnt >= 0) begin
                    check("rand latency", 32'(wait_cnt), 32'd3);
                    wait_cnt = -1;
                end
                check("rand busy", {31'h0, busy8}, 32'd1);
                check("rand in_ready in DONE", {31'h0, ir8}, 32'd0);
                if (q8.size() == 0) begin
                    check("rand spurious result", 32'd1, 32'd0);
                end else begin
                    check("rand sum", {24'h0, s8}, {24'h0, q8[0].s});
                    check("rand cout/ovf", {30'h0, co8, ovf8}, {30'h0, q8[0].c, q8[0].o});
                    if (or8) begin
                        void'(q8.pop_front());
                        results8++;
                    end
                end
            end
            if (iv8 && ir8) begin
                check("rand single outstanding", 32'(q8.size()), 32'd0);
                m = ref_add(8, {24'h0, a8}, {24'h0, b8}, cin8);
                q8.push_back('{s: m[7:0], c: m[32], o: m[33]});
                accepts8++;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        logic hs;
        int   cycles;
        repeat (3) @(posedge clk);
        #1;
        check("reset sum16", {16'h0, s16}, 32'h0);
        check("reset flags16", {27'h0, co16, ovf16, ov16, busy16, ir16}, 32'h0);
        check("reset outs8", {19'h0, s8, co8, ovf8, ov8, busy8, ir8}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready before first edge", {31'h0, ir16}, 32'd0);
        @(posedge clk); #1;
        check("in_ready after first edge", {30'h0, ir16, ir8}, 32'h3);

        run_op16("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op16("ffff+cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        run_op16("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3);
        run_op16("8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

        // Abort in the second RUN cycle
        @(posedge clk); #1;
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; iv16 = 1'b1;
        @(negedge clk);
        check("abort accept ready", {31'h0, ir16}, 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort sum", {16'h0, s16}, 32'h0);
        check("abort flags", {27'h0, co16, ovf16, ov16, busy16, ir16}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready low", {31'h0, ir16}, 32'd0);
        @(posedge clk); #1;
        check("abort in_ready high", {31'h0, ir16}, 32'd1);
        run_op16("post-abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        // Randomised traffic on the WIDTH=8 instance
        cycles = 0;
        while (results8 < 1000 && cycles < 40000) begin
            @(negedge clk);
            hs = iv8 && ir8;
            @(posedge clk); #1;
            cycles++;
            if (hs || !iv8) iv8 = ($urandom_range(0, 2) != 0);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            or8  = 1'($urandom_range(0, 1));
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        if (results8 < 1000) check("rand cycle budget", 32'(results8), 32'd1000);
        @(negedge clk);
        check("rand no lost ops", 32'(accepts8), 32'(results8 + q8.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
